csr_hex_display: RTL and testbench
==================================

CSR_HEX_DISPLAY -- requirements
Module: csr_hex_display

Interface
REQ-001 Parameter: BLANK_LEADING, default 1, meaning: 1 blanks leading zero digits in decimal mode.
REQ-002 Port: clk, input, 1, single clock; every flop in the block is clocked on its rising edge.
REQ-003 Port: rst, input, 1, reset; it is asynchronous and active-low, asserted when rst==0.
REQ-004 Port: value, input, 32, the CPU gpio_out word to display, sampled every clk.
REQ-005 Port: dec_mode, input, 1, display mode: 1 = unsigned decimal, 0 = eight hex nibbles.
REQ-006 Port: hex0..hex7, output, 7 each, active-low segments [6:0]=g..a; hex0 is the least significant digit.
REQ-007 Port: busy, output, 1, high while a conversion is in progress (state != IDLE).
REQ-008 Port: ovf, output, 1, high when the last latched decimal value is >= 100000000.

Function
REQ-009 FSM states SHALL be IDLE, CONVERT and LATCH.
REQ-010 The block SHALL hold a shadow copy of value and of dec_mode, plus a pending flag.
REQ-011 In IDLE, if value != shadow, dec_mode != shadow mode, or pending==1:
- capture value and dec_mode into the shadows;
- clear pending;
- go to CONVERT if dec_mode==1, otherwise go to LATCH.
REQ-012 CONVERT SHALL run a double-dabble conversion on a 40-bit BCD register (10 digits):
- one iteration per clock: add 3 to every BCD digit >= 5, then shift in the next shadow bit, MSB first;
- exactly 32 iterations, counted by a 6-bit counter;
- on the 32nd iteration, go to LATCH.
REQ-013 LATCH SHALL update all eight digit output registers and ovf in one clock, then return to IDLE.
REQ-014 Latency, decimal: a value change present before edge k SHALL appear on hex0..hex7 after edge k+33; hex mode: after edge k+1.
REQ-015 Input changes while busy==1 SHALL NOT disturb the conversion in flight. On return to IDLE the input is compared again, so the final stable value is always displayed.
REQ-016 Hex mode: digit i shows shadow nibble [4i+3:4i] using glyphs 0-9, A, b, C, d, E, F; no blanking; ovf is forced to 0.
REQ-017 Decimal mode:
- digit i shows BCD digit i (lower 8 digits only);
- ovf = 1 when BCD digit 8 or digit 9 is nonzero.
REQ-018 Blanking applies when BLANK_LEADING==1 and the mode is decimal:
- digits above the most significant nonzero digit are blank (7'h7F);
- value 0 shows "0" on hex0 only;
- when ovf==1, no digit is blanked.
REQ-019 Segment codes, active-low g..a:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000;
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 Outputs hex0..hex7, busy and ovf SHALL all be registered; there is no combinational path from the inputs to the outputs.

Reset
REQ-021 While rst==0, regardless of clk:
- state=IDLE; shadows=0; BCD register and counter = 0;
- pending=1; busy=0; ovf=0;
- hex0..hex7 = 7'h7F (blank).
REQ-022 Because pending is set at reset, the first clock after reset release SHALL start a conversion of the current input, even when value==0.
REQ-023 Reset asserted mid-conversion SHALL abort immediately, with no partial digits ever latched.

Structure
REQ-024 A shared package SHALL hold:
- the FSM state enum;
- the 16 segment glyph constants;
- SEG_BLANK=7'h7F;
- the iteration count constant 32.
REQ-025 One combinational sub-module, seg7_encoder (4-bit nibble in, 7-bit active-low segments out), SHALL be instantiated eight times.
REQ-026 Total RTL SHALL be 120-400 lines.

Verification
REQ-027 Reset release with value=0, dec_mode=1:
- after 34 clocks, hex0=1000000, hex1..hex7=1111111, ovf=0;
- busy is high for exactly 33 cycles.
REQ-028 value=32'd12345678, dec_mode=1:
- hex7..hex0 show 1,2,3,4,5,6,7,8;
- output update occurs on edge k+33 and no earlier.
REQ-029 value=32'hDEADBEEF, dec_mode=0:
- hex7..hex0 show d,E,A,d,b,E,E,F two edges after the change;
- ovf=0.
REQ-030 value=32'hFFFFFFFF, dec_mode=1:
- ovf=1;
- hex7..hex0 show 9,4,9,6,7,2,9,5, with no blanking.
REQ-031 value changed 5 then 42 while busy:
- the display first shows 5 (hex0=0010010, others blank);
- then, 34 clocks after IDLE, shows 42;
- no intermediate glyphs appear.
REQ-032 rst pulsed low for 1 cycle at iteration 16:
- outputs blank and busy=0 asynchronously;
- after release, a full conversion of the current value completes correctly.

Source files
------------

// File: rtl/csr_hex_display_pkg.sv
// rtl/csr_hex_display_pkg.sv - shared types, glyphs and BCD helper for the hex/decimal display
package csr_hex_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LATCH   = 2'd2
  } state_t;

  localparam int ITERATIONS = 32;

  // Active-low segments, bit order g..a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble correction step: every digit >= 5 gets +3 before the shift
  function automatic logic [39:0] bcd_add3(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/csr_hex_display_seg7_encoder.sv
// rtl/csr_hex_display_seg7_encoder.sv - nibble to active-low seven-segment glyph
module seg7_encoder
  import csr_hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/csr_hex_display.sv
// rtl/csr_hex_display.sv - eight-digit seven-segment display of a CPU word, hex or unsigned decimal
module csr_hex_display
  import csr_hex_display_pkg::*;
#(
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        dec_mode,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic        busy,
  output logic        ovf
);

  state_t      state, state_next;
  logic [31:0] shadow_value;
  logic        shadow_mode;
  logic        pending;
  logic [39:0] bcd;
  logic [39:0] bcd_adj;
  logic [5:0]  cnt;
  logic        start;
  logic        busy_q;
  logic        ovf_q;
  logic        dec_ovf;
  logic        seen_nz;
  logic [7:0]  blank;
  logic [3:0]  nibble [8];
  logic [6:0]  seg    [8];
  logic [6:0]  hex_q  [8];

  assign start   = (value != shadow_value) || (dec_mode != shadow_mode) || pending;
  assign bcd_adj = bcd_add3(bcd);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = dec_mode ? ST_CONVERT : ST_LATCH;
      ST_CONVERT: if (cnt == 6'(ITERATIONS - 1)) state_next = ST_LATCH;
      ST_LATCH:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != ST_IDLE);
    end
  end

  // Digit selection and leading-zero blanking, evaluated against the shadows
  always_comb begin
    dec_ovf = shadow_mode && (bcd[39:32] != 8'd0);
    seen_nz = 1'b0;
    blank   = 8'd0;
    for (int i = 7; i >= 1; i--) begin
      if (bcd[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      blank[i] = shadow_mode && (BLANK_LEADING == 1) && !dec_ovf && !seen_nz;
    end
    for (int i = 0; i < 8; i++) begin
      nibble[i] = shadow_mode ? bcd[4*i +: 4] : shadow_value[4*i +: 4];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_enc
    seg7_encoder u_enc (
      .nibble (nibble[g]),
      .seg    (seg[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_value <= 32'd0;
      shadow_mode  <= 1'b0;
      pending      <= 1'b1;
      bcd          <= 40'd0;
      cnt          <= 6'd0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < 8; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shadow_value <= value;
            shadow_mode  <= dec_mode;
            pending      <= 1'b0;
            bcd          <= 40'd0;
            cnt          <= 6'd0;
          end
        end
        ST_CONVERT: begin
          // Shadow bits enter MSB first; cnt selects the bit for this iteration
          bcd <= {bcd_adj[38:0], shadow_value[5'd31 - cnt[4:0]]};
          cnt <= cnt + 6'd1;
        end
        ST_LATCH: begin
          ovf_q <= dec_ovf;
          for (int i = 0; i < 8; i++) hex_q[i] <= blank[i] ? SEG_BLANK : seg[i];
        end
        default: ;
      endcase
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_csr_hex_display.sv
// tb/tb_csr_hex_display.sv - scoreboard bench for csr_hex_display
module tb_csr_hex_display;

  typedef struct packed {
    logic [55:0] hex;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic        dec_mode;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        busy;
  logic        ovf;

  int   vectors;
  int   miscompares;
  exp_t sb [$];

  csr_hex_display #(.BLANK_LEADING(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .dec_mode (dec_mode),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5),
    .hex6     (hex6),
    .hex7     (hex7),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] v, input logic m);
    exp_t        e;
    logic [3:0]  d [8];
    logic [31:0] t;
    int          top;
    e.hex = '0;
    e.ovf = 1'b0;
    if (!m) begin
      for (int i = 0; i < 8; i++) e.hex[7*i +: 7] = glyph(v[4*i +: 4]);
    end else begin
      t = v;
      for (int i = 0; i < 8; i++) begin
        d[i] = 4'(t % 10);
        t    = t / 10;
      end
      e.ovf = (t != 0);
      top = 0;
      for (int i = 0; i < 8; i++) if (d[i] != 0) top = i;
      for (int i = 0; i < 8; i++)
        e.hex[7*i +: 7] = (!e.ovf && i > top) ? 7'h7F : glyph(d[i]);
    end
    return e;
  endfunction

  function automatic logic [55:0] disp();
    return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] v, input logic m);
    @(posedge clk);
    #1;
    value    = v;
    dec_mode = m;
    sb.push_back(model(v, m));
  endtask

  // Waits for one conversion to finish; exp_busy < 0 skips the busy-length check
  task automatic wait_result(input string tag, input int exp_busy);
    int          n;
    logic        changed;
    logic [55:0] prev;
    logic        prev_ovf;
    exp_t        e;
    prev     = disp();
    prev_ovf = ovf;
    n        = 0;
    changed  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (disp() !== prev || ovf !== prev_ovf) changed = 1'b1;
      end else if (n > 0) begin
        break;
      end
    end
    if (exp_busy >= 0) check({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
    else check({tag, " busy_seen"}, 64'(n > 0), 64'd1);
    check({tag, " held_while_busy"}, 64'(changed), 64'd0);
    check({tag, " scoreboard_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, " hex"}, 64'(disp()), 64'(e.hex));
      check({tag, " ovf"}, 64'(ovf), 64'(e.ovf));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b0;
    value    = 32'd0;
    dec_mode = 1'b1;

    repeat (3) @(negedge clk);
    check("reset hex", 64'(disp()), {8'd0, {8{7'h7F}}});
    check("reset busy", 64'(busy), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);

    sb.push_back(model(32'd0, 1'b1));
    rst = 1'b1;
    wait_result("reset_zero", 33);

    drive(32'd12345678, 1'b1);
    wait_result("dec_12345678", 33);

    drive(32'hDEADBEEF, 1'b0);
    wait_result("hex_deadbeef", 1);

    drive(32'hFFFFFFFF, 1'b1);
    wait_result("dec_ffffffff", 33);

    drive(32'd100000000, 1'b1);
    wait_result("dec_1e8", 33);

    drive(32'd99999999, 1'b1);
    wait_result("dec_99999999", 33);

    drive(32'd0, 1'b0);
    wait_result("hex_zero", 1);

    drive(32'd0, 1'b1);
    wait_result("mode_only", 33);

    drive(32'd5, 1'b1);
    repeat (5) @(negedge clk);
    drive(32'd42, 1'b1);
    wait_result("busy_five", -1);
    wait_result("busy_fortytwo", 33);

    drive(32'd987654, 1'b1);
    repeat (16) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst hex", 64'(disp()), {8'd0, {8{7'h7F}}});
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_result("after_rst", 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
